// File: rtl/muldiv_if.sv
// Handshake and operand bundle between the EX stage and the iterative RV32M multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  busy, done, stall, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output busy, done, stall, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (radix-2 shift-add) / divide (restoring), one bit per cycle.
// state | meaning: IDLE wait for start | CALC iterate XLEN bits | DONE result valid, done pulse
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div_in = bus.funct3[2];
    sgn_a_in  = is_div_in ? ~bus.funct3[0] : (bus.funct3[0] ^ bus.funct3[1]);
    sgn_b_in  = is_div_in ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    neg_a_in  = sgn_a_in & bus.src_a[XLEN-1];
    neg_b_in  = sgn_b_in & bus.src_b[XLEN-1];
    mag_a     = neg_a_in ? -bus.src_a : bus.src_a;
    mag_b     = neg_b_in ? -bus.src_b : bus.src_b;
    // remainder takes the dividend's sign only
    neg_in    = (is_div_in && bus.funct3[1]) ? neg_a_in : (neg_a_in ^ neg_b_in);
    div_zero  = (bus.src_b == '0);
    div_ovf   = ~bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
    special   = is_div_in && (div_zero || div_ovf);
    if (div_zero) special_res = bus.funct3[1] ? bus.src_a : '1;
    else          special_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              q_bit;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod_fix;
  logic [XLEN-1:0]   mul_word, div_raw, div_word, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh    = acc_q[2*XLEN-1:XLEN-1];
    diff      = rem_sh - {1'b0, opnd_q};
    q_bit     = ~diff[XLEN];
    new_rem   = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_next  = {new_rem, acc_q[XLEN-2:0], q_bit};
    iter_next = op_q[2] ? div_next : mul_next;
    prod_fix  = neg_q ? -iter_next : iter_next;
    mul_word  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_raw   = op_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
    div_word  = neg_q ? -div_raw : div_raw;
    final_res = op_q[2] ? div_word : mul_word;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d = bus.funct3;
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            neg_d   = neg_in;
            opnd_d  = is_div_in ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = iter_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE) && !bus.flush;
  assign bus.stall  = bus.busy || (bus.start && (state_q == S_IDLE));
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] last_res;
  int          last_lat;
  int          stall_cnt;
  logic        stall_at_done;

  muldiv_if #(.XLEN(32)) ifc ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = '1; else if (ovf) r = a; else r = $signed(a) / $signed(b);
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a;  else if (ovf) r = '0; else r = $signed(a) % $signed(b);
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      4:       return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    @(negedge clk);
    ifc.funct3 = f;
    ifc.src_a  = a;
    ifc.src_b  = b;
    ifc.start  = 1'b1;
    stall_cnt  = 0;
    stall_at_done = 1'b1;
    last_lat   = -1;
    #1;
    if (ifc.stall) stall_cnt++;
    for (int c = 1; c <= 40 && last_lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) ifc.start = 1'b0;
        ifc.src_a  = $urandom;
        ifc.src_b  = $urandom;
        ifc.funct3 = 3'($urandom);
      end
      #1;
      if (ifc.done) begin
        last_lat      = c;
        last_res      = ifc.result;
        stall_at_done = ifc.stall;
        ifc.start     = 1'b0;
      end else if (ifc.stall) begin
        stall_cnt++;
      end
    end
    ifc.start = 1'b0;
    check_eq({tag, "_lat"}, last_lat, ref_lat(f, a, b));
    check_eq({tag, "_res"}, last_res, ref_op(f, a, b));
  endtask

  initial begin
    logic [31:0] prev;
    int          pulses;
    ifc.start  = 1'b0;
    ifc.flush  = 1'b0;
    ifc.funct3 = 3'd0;
    ifc.src_a  = '0;
    ifc.src_b  = '0;
    last_res   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy",   ifc.busy,   0);
    check_eq("rst_done",   ifc.done,   0);
    check_eq("rst_result", ifc.result, 0);
    reset = 1'b0;

    // latency / stall profile
    do_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check_eq("mul_7xm3_const", last_res, 32'hFFFF_FFEB);
    check_eq("mul_stall_cycles", stall_cnt, 33);
    check_eq("mul_stall_at_done", stall_at_done, 0);
    @(negedge clk); #1;
    check_eq("mul_busy_34", ifc.busy, 0);

    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("mulhu_const", last_res, 32'hFFFF_FFFE);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_eq("mulhsu_const", last_res, 32'hFFFF_FFFF);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_eq("mulh_const", last_res, 32'h4000_0000);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_m7_2_const", last_res, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("rem_m7_2_const", last_res, 32'hFFFF_FFFF);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0);
    check_eq("divu_const", last_res, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0);
    check_eq("remu_const", last_res, 32'd2);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 1'b0);
    check_eq("div_by0_const", last_res, 32'hFFFF_FFFF);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0, 1'b0);
    check_eq("remu_by0_const", last_res, 32'd5);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf_const", last_res, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("rem_ovf_const", last_res, 32'h0);

    // flush during CALC
    do_op("pre_flush", 3'd0, 32'd6, 32'd9, 1'b0);
    prev = last_res;
    @(negedge clk);
    ifc.funct3 = 3'd0; ifc.src_a = 32'd11; ifc.src_b = 32'd13; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    ifc.flush = 1'b1;
    #1;
    check_eq("flush_calc_done", ifc.done, 0);
    @(negedge clk); ifc.flush = 1'b0;
    #1;
    check_eq("flush_idle_busy", ifc.busy, 0);
    pulses = 0;
    repeat (30) begin @(negedge clk); #1; if (ifc.done) pulses++; end
    check_eq("flush_no_done", pulses, 0);
    check_eq("flush_result_kept", ifc.result, prev);

    // start held through CALC gives one pulse
    do_op("hold_start", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    pulses = 0;
    repeat (5) begin @(negedge clk); #1; if (ifc.done || ifc.busy) pulses++; end
    check_eq("hold_single_pulse", pulses, 0);

    // flush with start in IDLE suppresses start
    @(negedge clk);
    ifc.funct3 = 3'd4; ifc.src_a = 32'd5; ifc.src_b = 32'd0; ifc.start = 1'b1; ifc.flush = 1'b1;
    @(negedge clk); ifc.start = 1'b0; ifc.flush = 1'b0;
    #1;
    check_eq("flush_idle_start", {ifc.busy, ifc.done}, 0);

    // flush in DONE masks the pulse
    @(negedge clk);
    ifc.funct3 = 3'd5; ifc.src_a = 32'd9; ifc.src_b = 32'd0; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0; ifc.flush = 1'b1;
    #1;
    check_eq("flush_done_mask", ifc.done, 0);
    @(negedge clk); ifc.flush = 1'b0;

    // async reset in the middle of a DIVU
    @(negedge clk);
    ifc.funct3 = 3'd5; ifc.src_a = 32'd1000; ifc.src_b = 32'd3; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy",   ifc.busy,   0);
    check_eq("arst_stall",  ifc.stall,  0);
    check_eq("arst_done",   ifc.done,   0);
    check_eq("arst_result", ifc.result, 0);
    @(negedge clk); reset = 1'b0;
    do_op("post_rst_mul", 3'd0, 32'd3, 32'd4, 1'b0);
    check_eq("post_rst_const", last_res, 32'd12);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU, selected when the decoder flags an M-extension op (opcode 0110011, funct7 0000001).
- Multiply: radix-2 shift-add, one bit per cycle.
- Divide: restoring division, one bit per cycle.
- Owns a start/busy/done handshake and drives a stall request that holds IF/ID/EX while an operation is in flight.
- The hazard unit consumes the stall request; the EX result mux selects the result output when done is high.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  XLEN  rs1 operand (multiplicand / dividend)
src_b  input  XLEN  rs2 operand (multiplier / divisor)
flush  input  1  synchronous abort of the in-flight op (branch mispredict / pipeline flush)
busy  output  1  high in CALC
done  output  1  one-cycle pulse; result valid in that cycle
stall  output  1  busy OR (start AND state==IDLE)
result  output  XLEN  registered result; holds its value until the next op completes

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, all working registers=0. Reset mid-operation discards the op; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start=1 and the op is not a special divide case.
  - Latch funct3.
  - Convert operands to magnitudes per signedness: MULH both signed; MULHSU a signed, b unsigned; DIV/REM both signed; others unsigned.
  - Latch neg_result:
    - MUL*: sign_a XOR sign_b.
    - DIV: sign_a XOR sign_b.
    - REM: sign_a only.
  - Clear the 2*XLEN accumulator/remainder and set counter=0.
- IDLE -> DONE directly (special divide cases, latency 1):
  - Divide by zero (src_b==0): DIV/DIVU give all-ones; REM/REMU give src_a.
  - Signed overflow, DIV/REM with src_a=0x80000000 and src_b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC:
  - One iteration per cycle; counter increments.
  - On counter==XLEN-1 go to DONE. On that edge, write result with sign correction (two's-complement negate if neg_result).
  - Multiply word select: MUL takes the low word of the 64-bit product; MULH/MULHSU/MULHU take the high word.
  - Negation applies to the full 64-bit product before the word is selected.
  - Divide: quotient for DIV/DIVU, remainder for REM/REMU.
- Latency: start at cycle 0 gives CALC in cycles 1..32 and DONE in cycle 33 (done=1, stall=0).
- DONE -> IDLE unconditionally. A start in DONE is ignored; the pipeline reissues in the following cycle.
- start in CALC is ignored; operands are not re-sampled.
- flush=1 in CALC or DONE: next state IDLE, done forced 0, result unchanged. flush has priority over start and over iteration completion.
- flush=1 in IDLE with start=1: start is suppressed.
- All arithmetic is modulo 2^XLEN. The intermediate product is 2*XLEN bits; remainder compare/subtract is XLEN+1 bits.

Test Plan:
1. MUL src_a=7, src_b=0xFFFFFFFD (-3) -> stall high cycles 0..32; done pulse at cycle 33 with result=0xFFFFFFEB; busy low at 34.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU src_a=0xFFFFFFFF (-1), src_b=2 -> 0xFFFFFFFF. MULH 0x80000000 x 0x80000000 -> 0x40000000.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 5/0 -> done at cycle 1, result 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM same operands -> 0.
5. Start MUL, assert flush at cycle 10 -> state IDLE at cycle 11, no done pulse, result keeps its prior value. start held high during CALC -> exactly one done pulse.
6. Assert reset asynchronously (mid-cycle) at cycle 20 of a DIVU -> busy/stall/done/result drop to 0 immediately. A new MUL 3x4 after release -> result 12 after 33 cycles.
